// File: rtl/dmem_responder.sv
// dmem_responder: busywait data-memory responder with fixed latency and byte/half/word access
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        ERROR
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, a1, a2, a3;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, load;
    logic [2:0] func3_q, func3_d;
    logic rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic req, access, illegal, we;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] mem_q [2**ADDR_WIDTH];

    assign req      = READ | WRITE;
    assign BUSYWAIT = req && state_q != DONE;
    assign READDATA = rdata_q;
    assign ERROR    = err_q;
    assign access   = state_q == BUSY && req && cnt_q == 4'd0;
    // Loads reject 011/110/111, stores reject anything above 010.
    assign illegal  = (rd_q && wr_q)
                   || (wr_q ? func3_q > 3'd2 : (func3_q[1:0] == 2'b11 || func3_q == 3'b110))
                   || (func3_q[1:0] == 2'b01 && addr_q[0])
                   || (func3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    assign we       = access && RESET && wr_q && !illegal;
    assign a1       = addr_q + ADDR_WIDTH'(1);
    assign a2       = addr_q + ADDR_WIDTH'(2);
    assign a3       = addr_q + ADDR_WIDTH'(3);
    assign b0       = mem_q[addr_q];
    assign b1       = mem_q[a1];
    assign b2       = mem_q[a2];
    assign b3       = mem_q[a3];
    assign load     = func3_q[1] ? {b3, b2, b1, b0}
                    : func3_q[0] ? {{16{b1[7] & ~func3_q[2]}}, b1, b0}
                    : {{24{b0[7] & ~func3_q[2]}}, b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        func3_d = func3_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY - 1);
                addr_d  = ADDRESS[ADDR_WIDTH-1:0];
                wdata_d = WRITEDATA;
                func3_d = FUNC3;
                rd_d    = READ;
                wr_d    = WRITE;
            end
            BUSY: if (!req) state_d = IDLE;
                else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else begin
                    state_d = DONE;
                    err_d   = illegal;
                    rdata_d = (rd_q && !illegal) ? load : 32'd0;
                end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            func3_q <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[addr_q] <= wdata_q[7:0];
            if (func3_q[1:0] != 2'b00) mem_q[a1] <= wdata_q[15:8];
            if (func3_q[1]) begin
                mem_q[a2] <= wdata_q[23:16];
                mem_q[a3] <= wdata_q[31:24];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-array model
module tb_dmem_responder;
    localparam int LAT = 4;
    logic        CLK = 1'b0, RESET = 1'b0, READ = 1'b0, WRITE = 1'b0;
    logic [31:0] ADDRESS = 32'd0, WRITEDATA = 32'd0, READDATA;
    logic [2:0]  FUNC3 = 3'd0;
    logic        BUSYWAIT, ERROR;
    int vectors = 0, errors = 0;
    logic [7:0]  m [1024];
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err = 1'b0;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .FUNC3(FUNC3), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    // Reference: whole-access semantics on a flat byte array.
    function automatic void ref_access(input logic rd, wr, input logic [31:0] a, wd, input logic [2:0] f3);
        int base = int'(a[9:0]);
        int sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        bit legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        logic [31:0] v = 32'd0;
        exp_err = (rd && wr) || !legal || (base % sz != 0);
        exp_rdata = 32'd0;
        if (!exp_err && wr)
            for (int i = 0; i < sz; i++) m[(base + i) % 1024] = wd[8*i +: 8];
        if (!exp_err && rd) begin
            for (int i = 0; i < sz; i++) v = v | (32'(m[(base + i) % 1024]) << (8 * i));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            exp_rdata = v;
        end
    endfunction

    task automatic access(input logic rd, wr, input logic [31:0] a, wd, input logic [2:0] f3,
                          output int nb, output logic [31:0] rdata, output logic err, output bit done);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd; FUNC3 = f3;
        nb = 0; done = 0; rdata = 32'd0; err = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                ADDRESS = $urandom; WRITEDATA = $urandom; FUNC3 = 3'($urandom_range(0, 7));
            end
            if (BUSYWAIT) nb++;
            else begin
                done = 1; rdata = READDATA; err = ERROR;
            end
        end
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (READDATA !== 32'd0 || ERROR !== 1'b0 || BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdata=%h err=%b busy=%b, want 0/0/0", READDATA, ERROR, BUSYWAIT);
        end
        @(posedge CLK); #1;
        RESET = 1'b1;
    endtask

    task automatic test_fill();
        int nb; logic [31:0] rd, wd; logic err; bit done;
        for (int w = 0; w < 256; w++) begin
            wd = $urandom;
            access(1'b0, 1'b1, 32'(w * 4), wd, 3'd2, nb, rd, err, done);
            ref_access(1'b0, 1'b1, 32'(w * 4), wd, 3'd2);
            vectors++;
            if (!done || nb != LAT + 1 || err !== 1'b0) begin
                errors++;
                $display("FAIL fill w%0d: done=%0d busy=%0d err=%b, want 1/%0d/0", w, done, nb, err, LAT + 1);
            end
        end
    endtask

    typedef struct { logic rd, wr; logic [31:0] a, wd; logic [2:0] f3; logic [31:0] er; logic ee; } dir_t;

    task automatic test_directed();
        int nb; logic [31:0] rd; logic err; bit done;
        dir_t t [11] = '{
            '{0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0,        1'b0},
            '{1, 0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0},
            '{1, 0, 32'h13, 32'h0,        3'd0, 32'hFFFFFFDE, 1'b0},
            '{1, 0, 32'h13, 32'h0,        3'd4, 32'h000000DE, 1'b0},
            '{1, 0, 32'h10, 32'h0,        3'd1, 32'hFFFFBEEF, 1'b0},
            '{1, 0, 32'h12, 32'h0,        3'd5, 32'h0000DEAD, 1'b0},
            '{0, 1, 32'h11, 32'h000000AA, 3'd0, 32'h0,        1'b0},
            '{1, 0, 32'h10, 32'h0,        3'd2, 32'hDEADAAEF, 1'b0},
            '{1, 0, 32'h12, 32'h0,        3'd2, 32'h0,        1'b1},
            '{0, 1, 32'h11, 32'h0000FFFF, 3'd1, 32'h0,        1'b1},
            '{1, 0, 32'h10, 32'h0,        3'd2, 32'hDEADAAEF, 1'b0}
        };
        foreach (t[i]) begin
            access(t[i].rd, t[i].wr, t[i].a, t[i].wd, t[i].f3, nb, rd, err, done);
            ref_access(t[i].rd, t[i].wr, t[i].a, t[i].wd, t[i].f3);
            vectors++;
            if (!done || nb != LAT + 1 || err !== t[i].ee || (t[i].rd && rd !== t[i].er)) begin
                errors++;
                $display("FAIL directed %0d: done=%0d busy=%0d err=%b rdata=%h, want busy=%0d err=%b rdata=%h",
                         i, done, nb, err, rd, LAT + 1, t[i].ee, t[i].er);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nb; logic [31:0] rd; logic err; bit done;
        WRITE = 1'b1; ADDRESS = 32'h20; WRITEDATA = 32'h12345678; FUNC3 = 3'd2;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1; WRITE = 1'b0;
        exp_rdata = 32'd0; exp_err = 1'b0;
        @(negedge CLK);
        vectors++;
        if (READDATA !== 32'd0 || ERROR !== 1'b0 || BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdata=%h err=%b busy=%b, want 0/0/0", READDATA, ERROR, BUSYWAIT);
        end
        @(posedge CLK); #1;
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'd2, nb, rd, err, done);
        ref_access(1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
        vectors++;
        if (!done || nb != LAT + 1 || err !== 1'b0 || rd !== exp_rdata) begin
            errors++;
            $display("FAIL reset_mid LW: done=%0d busy=%0d err=%b rdata=%h, want %0d/0/%h", done, nb, err, rd, LAT + 1, exp_rdata);
        end
    endtask

    task automatic test_withdraw();
        int nb; logic [31:0] rd; logic err; bit done;
        access(1'b1, 1'b0, 32'h12, 32'h0, 3'd2, nb, rd, err, done);
        ref_access(1'b1, 1'b0, 32'h12, 32'h0, 3'd2);
        READ = 1'b1; ADDRESS = 32'h10; FUNC3 = 3'd2;
        repeat (3) @(posedge CLK);
        #1 READ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            vectors++;
            if (BUSYWAIT !== 1'b0 || READDATA !== exp_rdata || ERROR !== exp_err) begin
                errors++;
                $display("FAIL withdraw c%0d: busy=%b rdata=%h err=%b, want 0/%h/%b", i, BUSYWAIT, READDATA, ERROR, exp_rdata, exp_err);
            end
        end
        @(posedge CLK); #1;
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2, nb, rd, err, done);
        ref_access(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        vectors++;
        if (!done || nb != LAT + 1 || err !== 1'b0 || rd !== exp_rdata) begin
            errors++;
            $display("FAIL withdraw LW: done=%0d busy=%0d err=%b rdata=%h, want %0d/0/%h", done, nb, err, rd, LAT + 1, exp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int nb, k; logic [31:0] rd, a, wd; logic err, r, w; logic [2:0] f3; bit done;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            r = k < 5 || k == 9; w = k >= 5;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            wd = $urandom; f3 = 3'($urandom_range(0, 7));
            access(r, w, a, wd, f3, nb, rd, err, done);
            ref_access(r, w, a, wd, f3);
            vectors++;
            if (!done || nb != LAT + 1 || err !== exp_err || (r && rd !== exp_rdata)) begin
                errors++;
                $display("FAIL random %0d r%b w%b a=%h f3=%0d: done=%0d busy=%0d err=%b rdata=%h, want %0d/%b/%h",
                         n, r, w, a, f3, done, nb, err, rd, LAT + 1, exp_err, exp_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_reset_mid();
        test_withdraw();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port.
- Accepts a load or store request from the MEM stage (READ/WRITE, ADDRESS, WRITEDATA, FUNC3) and holds the pipeline with BUSYWAIT for a fixed access latency.
- Performs byte/half/word little-endian access, with sign or zero extension on loads.
- Sits between mem_unit and the backing store; it is the responder end of the CPU's busywait memory handshake.

Parameters:
- ADDR_WIDTH, 10, byte-address bits used for the internal array (2^ADDR_WIDTH bytes); upper ADDRESS bits are ignored.
- LATENCY, 4, cycles spent in BUSY before the access is performed; legal range 1..15.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- READ  input  1  load request; held by the requester until BUSYWAIT is low.
- WRITE  input  1  store request; same hold rule as READ.
- ADDRESS  input  32  byte address.
- WRITEDATA  input  32  store data; the low byte or low half is used for SB/SH.
- FUNC3  input  3  access size and type (RV32I load/store encoding).
- READDATA  output  32  load result; valid while state is DONE.
- BUSYWAIT  output  1  stall request to the pipeline; combinational.
- ERROR  output  1  high in DONE if the completed access was illegal.

Behaviour:
- States: IDLE, BUSY, DONE. Counter cnt is 4 bits wide.
- Reset (RESET==0 at an edge):
  - state=IDLE, cnt=0, READDATA=0, ERROR=0.
  - Array contents are not cleared; no write occurs in a reset cycle.
  - Reset mid-BUSY aborts the access with no memory side effect.
- BUSYWAIT = (READ|WRITE) && state!=DONE, evaluated combinationally. It rises in the same cycle a request appears.
- IDLE:
  - If READ|WRITE: latch ADDRESS, WRITEDATA, FUNC3 and type; cnt<=LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If READ and WRITE are both low (request withdrawn): return to IDLE with no access.
  - Else if cnt!=0: cnt<=cnt-1.
  - Else (cnt==0): perform the access on the latched values and go to DONE.
- DONE:
  - BUSYWAIT is low, so the pipeline advances at this edge.
  - Next state is unconditionally IDLE; READDATA and ERROR hold their values until the next DONE or reset.
  - A new request presented in that following cycle starts from IDLE.
- Latency: BUSYWAIT is high for exactly LATENCY+1 cycles per request, then low for one cycle (DONE).
- Latched inputs: changes to ADDRESS/WRITEDATA/FUNC3 after the IDLE->BUSY edge are ignored.
- Loads (little-endian):
  - LB 000 and LBU 100: byte at addr, sign- or zero-extended.
  - LH 001 and LHU 101: bytes addr and addr+1, extended.
  - LW 010: bytes addr..addr+3.
- Stores:
  - SB 000 writes WRITEDATA[7:0].
  - SH 001 writes [15:0].
  - SW 010 writes [31:0].
  - Other bytes are untouched.
- Illegal accesses set ERROR=1 in DONE, force READDATA=0, and suppress any write. Illegal means any of:
  - READ and WRITE both high at latch;
  - FUNC3 not in the legal set (loads: 000/001/010/100/101; stores: 000/001/010);
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- A legal access drives ERROR=0 in DONE.
- Address wrap: only addr[ADDR_WIDTH-1:0] is used; aligned accesses never straddle the top of the array.

Test Plan:
- Reset then SW: ADDRESS=0x10, WRITEDATA=0xDEADBEEF, FUNC3=010, LATENCY=4.
  - Required: BUSYWAIT high for 5 cycles, low for 1; ERROR=0.
  - A following LW to 0x10 returns READDATA=0xDEADBEEF in its DONE cycle.
- Byte/half extension: after the store above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- Partial store: SB 0x11 with WRITEDATA=0x000000AA, then LW 0x10 -> 0xDEADAABE... must instead be read as 0xDEADAAEF (only byte 1 replaced).
- Misalignment:
  - LW 0x12 -> DONE with ERROR=1, READDATA=0.
  - SH 0x11, WRITEDATA=0xFFFF -> ERROR=1; a subsequent LW 0x10 is unchanged.
- Reset mid-operation: assert RESET=0 during the 2nd BUSY cycle of SW 0x20 = 0x12345678.
  - Required: state IDLE, READDATA=0; a later LW 0x20 returns the pre-existing contents, not 0x12345678.
- Back-to-back and withdrawal:
  - LW immediately following a DONE: BUSYWAIT re-rises in the cycle after DONE.
  - Dropping READ during BUSY returns to IDLE with BUSYWAIT=0 and no DONE/ERROR update.
